// File: rtl/mdu_issue_ctrl_if.sv
// mdu_pkg operation/control types plus the signal bundle shared by execute, mdu, writeback and the issue controller.
// The controller uses the slave modport; the surrounding pipeline/mdu side uses master.
package mdu_pkg;
    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7
    } mdu_op_t;

    typedef struct packed {
        logic    enable;
        mdu_op_t operation;
    } mdu_ctrl_t;
endpackage

interface mdu_issue_ctrl_if #(
    parameter int REG_WIDTH = 32,
    parameter int TAG_WIDTH = 5
);
    import mdu_pkg::*;

    logic                 i_req_valid;
    logic                 o_req_ready;
    mdu_op_t              i_req_op;
    logic [REG_WIDTH-1:0] i_req_op1;
    logic [REG_WIDTH-1:0] i_req_op2;
    logic [TAG_WIDTH-1:0] i_req_tag;
    logic                 i_flush;
    mdu_ctrl_t            o_mdu_control;
    logic [REG_WIDTH-1:0] o_mdu_op1;
    logic [REG_WIDTH-1:0] o_mdu_op2;
    logic [REG_WIDTH-1:0] i_mdu_result;
    logic                 i_mdu_cooking;
    logic                 o_wb_valid;
    logic                 i_wb_ready;
    logic [REG_WIDTH-1:0] o_wb_result;
    logic [TAG_WIDTH-1:0] o_wb_tag;
    logic                 o_busy;

    modport slave (
        input  i_req_valid, i_req_op, i_req_op1, i_req_op2, i_req_tag, i_flush,
               i_mdu_result, i_mdu_cooking, i_wb_ready,
        output o_req_ready, o_mdu_control, o_mdu_op1, o_mdu_op2,
               o_wb_valid, o_wb_result, o_wb_tag, o_busy
    );

    modport master (
        output i_req_valid, i_req_op, i_req_op1, i_req_op2, i_req_tag, i_flush,
               i_mdu_result, i_mdu_cooking, i_wb_ready,
        input  o_req_ready, o_mdu_control, o_mdu_op1, o_mdu_op2,
               o_wb_valid, o_wb_result, o_wb_tag, o_busy
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Single-outstanding issue controller for the fixed-latency mdu: accept, issue, count STAGES, hand result to writeback.
// Optional macro MDU_DIV0_BYPASS_EN answers divide-by-zero locally without using the mdu.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int STAGES    = 5,
    parameter int TAG_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    mdu_issue_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(STAGES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mdu_op_t              op_q, op_d;
    logic [REG_WIDTH-1:0] op1_q, op1_d;
    logic [REG_WIDTH-1:0] op2_q, op2_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [REG_WIDTH-1:0] res_q, res_d;
    logic [TAG_WIDTH-1:0] wb_tag_q, wb_tag_d;
    logic                 req_ready;
    logic                 accept;

    always_comb begin
        req_ready = !bus.i_flush && !bus.i_mdu_cooking &&
                    ((state_q == IDLE) || ((state_q == DONE) && bus.i_wb_ready));
        accept    = bus.i_req_valid && req_ready;

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        tag_d    = tag_q;
        res_d    = res_q;
        wb_tag_d = wb_tag_q;

        if (accept) begin
            op_d  = bus.i_req_op;
            op1_d = bus.i_req_op1;
            op2_d = bus.i_req_op2;
            tag_d = bus.i_req_tag;
        end

        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(STAGES);
            end
            WAIT: begin
                // the mdu result is valid exactly on the last counted cycle
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    res_d    = bus.i_mdu_result;
                    wb_tag_d = tag_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: if (bus.i_wb_ready) state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

`ifdef MDU_DIV0_BYPASS_EN
        // divide by zero never reaches the mdu; RISC-V defines the answer
        if (accept && (bus.i_req_op2 == '0) &&
            (bus.i_req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})) begin
            state_d  = DONE;
            res_d    = (bus.i_req_op inside {OP_DIV, OP_DIVU}) ? '1 : bus.i_req_op1;
            wb_tag_d = bus.i_req_tag;
        end
`endif

        if (bus.i_flush && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            op1_q    <= '0;
            op2_q    <= '0;
            tag_q    <= '0;
            res_q    <= '0;
            wb_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            tag_q    <= tag_d;
            res_q    <= res_d;
            wb_tag_q <= wb_tag_d;
        end
    end

    assign bus.o_req_ready             = req_ready;
    assign bus.o_mdu_control.enable    = (state_q == ISSUE);
    assign bus.o_mdu_control.operation = op_q;
    assign bus.o_mdu_op1               = op1_q;
    assign bus.o_mdu_op2               = op2_q;
    assign bus.o_wb_valid              = (state_q == DONE);
    assign bus.o_wb_result             = res_q;
    assign bus.o_wb_tag                = wb_tag_q;
    assign bus.o_busy                  = (state_q != IDLE);
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: a fixed-latency mdu stand-in plus a transaction-level expectation model
// (one outstanding op, its accept cycle and RISC-V result); directed scenarios then random traffic.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int ST = 5;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cook_extra = 1'b0;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if #(.REG_WIDTH(W), .TAG_WIDTH(TW)) bus ();

    mdu_issue_ctrl #(.REG_WIDTH(W), .STAGES(ST), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics; codes outside the defined set yield 0
    function automatic logic [W-1:0] rv_m(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'd0: begin p = ua * ub; return p[31:0]; end
            4'd1: begin p = sa * sb; return p[63:32]; end
            4'd2: begin p = sa * ub; return p[63:32]; end
            4'd3: begin p = ua * ub; return p[63:32]; end
            4'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                return $signed(a) / $signed(b);
            end
            4'd5: return (b == 0) ? '1 : a / b;
            4'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            4'd7: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // mdu stand-in: ST-deep pipeline, cooking while any stage holds an op (or when the bench forces it)
    logic [ST-1:0] pv;
    logic [W-1:0]  pr [ST];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < ST; i++) pr[i] <= '0;
        end else begin
            pv    <= {pv[ST-2:0], bus.o_mdu_control.enable};
            pr[0] <= rv_m(bus.o_mdu_control.operation, bus.o_mdu_op1, bus.o_mdu_op2);
            for (int i = 1; i < ST; i++) pr[i] <= pr[i-1];
        end
    end
    assign bus.i_mdu_result  = pr[ST-1];
    assign bus.i_mdu_cooking = cook_extra | (|pv);

    // expectation model: at most one op, timed from the cycle it was accepted
    int          cyc = 0;
    bit          have_op = 0;
    bit          bypass_op = 0;
    bit          res_known = 0;
    int          acc_cyc = 0;
    logic [3:0]  exp_op;
    logic [W-1:0] exp_a, exp_b, exp_res;
    logic [TW-1:0] exp_tag;
    logic [W-1:0] last_res = '0;
    logic [TW-1:0] last_tag = '0;

    task automatic eval();
        int lat;
        bit ev, eb, een, er;
        lat = bypass_op ? 1 : ST + 2;
        ev  = have_op && (cyc >= acc_cyc + lat);
        eb  = have_op && (cyc >= acc_cyc + 1);
        een = have_op && !bypass_op && (cyc == acc_cyc + 1);
        er  = !bus.i_flush && !bus.i_mdu_cooking && (!have_op || (ev && bus.i_wb_ready));
        check("wb_valid", 64'(bus.o_wb_valid), 64'(ev));
        check("busy", 64'(bus.o_busy), 64'(eb));
        check("enable", 64'(bus.o_mdu_control.enable), 64'(een));
        check("req_ready", 64'(bus.o_req_ready), 64'(er));
        if (eb && !ev && !bypass_op) begin
            check("mdu_operation", 64'(bus.o_mdu_control.operation), 64'(exp_op));
            check("mdu_op1", 64'(bus.o_mdu_op1), 64'(exp_a));
            check("mdu_op2", 64'(bus.o_mdu_op2), 64'(exp_b));
        end
        if (ev) begin
            if (res_known) check("wb_result", 64'(bus.o_wb_result), 64'(exp_res));
            check("wb_tag", 64'(bus.o_wb_tag), 64'(exp_tag));
        end
        if (bus.i_flush) begin
            have_op = 0;
        end else begin
            if (ev && bus.i_wb_ready) begin
                last_res = bus.o_wb_result;
                last_tag = bus.o_wb_tag;
                $display("wb  cyc=%0d op=%0d a=%h b=%h tag=%0d result=%h", cyc, exp_op, exp_a, exp_b,
                         bus.o_wb_tag, bus.o_wb_result);
                have_op = 0;
            end
            if (bus.i_req_valid && er) begin
                have_op   = 1;
                acc_cyc   = cyc;
                exp_op    = 4'(bus.i_req_op);
                exp_a     = bus.i_req_op1;
                exp_b     = bus.i_req_op2;
                exp_tag   = bus.i_req_tag;
                res_known = (exp_op < 4'd8);
                exp_res   = rv_m(exp_op, exp_a, exp_b);
`ifdef MDU_DIV0_BYPASS_EN
                bypass_op = (exp_op >= 4'd4) && (exp_op <= 4'd7) && (exp_b == 0);
`else
                bypass_op = 0;
`endif
            end
        end
        cyc++;
    endtask

    task automatic step(input bit v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input bit fl, input bit wr, input bit ck);
        @(posedge clk);
        #1;
        bus.i_req_valid = v;
        bus.i_req_op    = mdu_op_t'(op);
        bus.i_req_op1   = a;
        bus.i_req_op2   = b;
        bus.i_req_tag   = t;
        bus.i_flush     = fl;
        bus.i_wb_ready  = wr;
        cook_extra      = ck;
        @(negedge clk);
        eval();
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) step(0, 4'd0, '0, '0, '0, 0, wr, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_control", 64'(bus.o_mdu_control), 64'(0));
        check("rst_op1", 64'(bus.o_mdu_op1), 64'(0));
        check("rst_op2", 64'(bus.o_mdu_op2), 64'(0));
        check("rst_wb_valid", 64'(bus.o_wb_valid), 64'(0));
        check("rst_wb_result", 64'(bus.o_wb_result), 64'(0));
        check("rst_wb_tag", 64'(bus.o_wb_tag), 64'(0));
        check("rst_busy", 64'(bus.o_busy), 64'(0));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bus.i_req_valid = 0;
        bus.i_req_op    = OP_MUL;
        bus.i_req_op1   = '0;
        bus.i_req_op2   = '0;
        bus.i_req_tag   = '0;
        bus.i_flush     = 0;
        bus.i_wb_ready  = 0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: MUL 7 * -3, tag 9
        step(1, 4'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0, 1, 0);
        idle(9, 1);
        check("t1_result", 64'(last_res), 64'h0000_0000_FFFF_FFEB);
        check("t1_tag", 64'(last_tag), 64'd9);

        // 2: MULHU with writeback stalled 4 cycles after result
        step(1, 4'd3, '1, '1, 5'd2, 0, 0, 0);
        idle(ST + 5, 0);
        idle(2, 1);
        check("t2_result", 64'(last_res), 64'h0000_0000_FFFF_FFFE);

        // 3: back-to-back DIVU 100/7, second op waits for DONE && wb_ready
        step(1, 4'd5, 32'd100, 32'd7, 5'd3, 0, 1, 0);
        for (int i = 0; i < ST + 2; i++) step(1, 4'd5, 32'd100, 32'd7, 5'd4, 0, 1, 0);
        idle(ST + 3, 1);
        check("t3_result", 64'(last_res), 64'd14);
        check("t3_tag", 64'(last_tag), 64'd4);

        // 4: flush REM -7%2 mid-WAIT, then a new op waits for the mdu to drain
        step(1, 4'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1, 0);
        idle(3, 1);
        step(0, 4'd0, '0, '0, '0, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 4'd0, 32'd6, 32'd7, 5'd6, 0, 1, 0);
        idle(ST + 4, 1);
        check("t4_result", 64'(last_res), 64'd42);
        check("t4_tag", 64'(last_tag), 64'd6);

        // 5: DIV 5/0
        step(1, 4'd4, 32'd5, 32'd0, 5'd7, 0, 1, 0);
        idle(ST + 3, 1);
        check("t5_result", 64'(last_res), 64'h0000_0000_FFFF_FFFF);
        check("t5_tag", 64'(last_tag), 64'd7);

        // 6: asynchronous reset while waiting on the mdu
        step(1, 4'd1, 32'd1234, 32'd5678, 5'd8, 0, 1, 0);
        idle(3, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        have_op = 0;
        bus.i_req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(ST + 4, 1);

        // random traffic, including undefined op codes, flushes and extra cooking
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 9)), pick_operand(), pick_operand(),
                 TW'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
        end
        idle(ST + 4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
